// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access.
// Data requests win unless a fetch has been starved; a watchdog aborts hung accesses.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ram_ready,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  localparam logic [7:0]  STARVE_MAX = 8'(STARVE_LIMIT);
  localparam logic [7:0]  TMO_MAX    = 8'(TIMEOUT);
  localparam logic [31:0] ABORT_WORD = 32'hBAD1_BAD1;

  state_t      state_reg;
  logic [7:0]  starve_cnt_reg;
  logic [7:0]  tmo_cnt_reg;
  logic        bus_err_reg;
  logic [31:0] iload_reg;
  logic [31:0] dload_reg;

  logic d_req, d_read;
  logic serve_i, serve_d;
  logic tmo_hit;
  logic i_done, i_abort, d_done, d_abort;
  logic i_starved;

  assign d_req     = dREN | dWEN;
  assign d_read    = dREN & ~dWEN;
  assign i_starved = iREN && (starve_cnt_reg == STARVE_MAX);

  // Service is only live while the granted requester keeps its enables up.
  assign serve_i = (state_reg == SERVE_I) && iREN;
  assign serve_d = (state_reg == SERVE_D) && d_req;
  assign tmo_hit = (tmo_cnt_reg == TMO_MAX) && !ram_ready;

  assign i_done  = serve_i && ram_ready;
  assign i_abort = serve_i && tmo_hit;
  assign d_done  = serve_d && ram_ready;
  assign d_abort = serve_d && tmo_hit;

  assign ramREN   = serve_i | (serve_d & d_read);
  assign ramWEN   = serve_d & dWEN;
  assign ramaddr  = serve_i ? iaddr : (serve_d ? daddr : 32'h0);
  assign ramstore = serve_d ? dstore : 32'h0;

  assign iwait = iREN  & ~(i_done | i_abort);
  assign dwait = d_req & ~(d_done | d_abort);

  assign iload = i_done ? ramload :
                 (i_abort ? ABORT_WORD : iload_reg);
  assign dload = (d_done && d_read) ? ramload :
                 (d_abort ? ABORT_WORD : dload_reg);

  assign bus_err = bus_err_reg;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg      <= IDLE;
      starve_cnt_reg <= 8'd0;
      tmo_cnt_reg    <= 8'd0;
      bus_err_reg    <= 1'b0;
      iload_reg      <= 32'h0;
      dload_reg      <= 32'h0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (d_req && !i_starved) begin
            state_reg   <= SERVE_D;
            tmo_cnt_reg <= 8'd0;
            if (!iREN)
              starve_cnt_reg <= 8'd0;
            else if (starve_cnt_reg != STARVE_MAX)
              starve_cnt_reg <= starve_cnt_reg + 8'd1;
          end else if (iREN) begin
            state_reg      <= SERVE_I;
            tmo_cnt_reg    <= 8'd0;
            starve_cnt_reg <= 8'd0;
          end else begin
            starve_cnt_reg <= 8'd0;
          end
        end

        SERVE_I: begin
          if (!iREN || ram_ready || tmo_hit)
            state_reg <= IDLE;
          else
            tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
          if (i_done)
            iload_reg <= ramload;
          if (i_abort)
            bus_err_reg <= 1'b1;
        end

        SERVE_D: begin
          if (!d_req || ram_ready || tmo_hit)
            state_reg <= IDLE;
          else
            tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
          if (d_done && d_read)
            dload_reg <= ramload;
          if (d_abort)
            bus_err_reg <= 1'b1;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one task per scenario, inline checks.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN, ram_ready;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        iwait, dwait, ramREN, ramWEN, bus_err;

  int passed = 0;
  int total  = 0;

  mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(8)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready), .bus_err(bus_err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0; ram_ready = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
    #1;
    total++; if (ramREN !== 1'b0) $display("FAIL rst_ramREN got %h exp 0", ramREN); else passed++;
    total++; if (ramaddr !== 32'h0) $display("FAIL rst_ramaddr got %h exp 0", ramaddr); else passed++;
    total++; if (iload !== 32'h0 || dload !== 32'h0) $display("FAIL rst_loads got %h/%h exp 0/0", iload, dload); else passed++;
    total++; if (bus_err !== 1'b0) $display("FAIL rst_bus_err got %h exp 0", bus_err); else passed++;
    iREN = 1; dWEN = 1;
    #1;
    total++; if (iwait !== 1'b1 || dwait !== 1'b1) $display("FAIL rst_waits got %b%b exp 11", iwait, dwait); else passed++;
    total++; if (ramWEN !== 1'b0 || ramREN !== 1'b0) $display("FAIL rst_ram_en got %b%b exp 00", ramWEN, ramREN); else passed++;
    iREN = 0; dWEN = 0;
    cyc();
    nRST = 1'b1;
    #1;
    $display("test_reset done");
  endtask

  task automatic test_ifetch();
    iREN = 1; iaddr = 32'h40;
    #1;
    total++; if (iwait !== 1'b1 || ramREN !== 1'b0) $display("FAIL if_idle got iwait=%b ramREN=%b exp 1/0", iwait, ramREN); else passed++;
    cyc();
    total++; if (ramREN !== 1'b1 || ramaddr !== 32'h40) $display("FAIL if_c1 got ren=%b addr=%h exp 1/40", ramREN, ramaddr); else passed++;
    cyc();
    total++; if (ramREN !== 1'b1 || iwait !== 1'b1) $display("FAIL if_c2 got ren=%b iwait=%b exp 1/1", ramREN, iwait); else passed++;
    cyc();
    ram_ready = 1; ramload = 32'h8C22_0004;
    #1;
    total++; if (iwait !== 1'b0 || iload !== 32'h8C22_0004) $display("FAIL if_done got iwait=%b iload=%h exp 0/8c220004", iwait, iload); else passed++;
    cyc();
    iREN = 0; ram_ready = 0; ramload = 32'h0;
    #1;
    total++; if (ramREN !== 1'b0 || iload !== 32'h8C22_0004) $display("FAIL if_hold got ren=%b iload=%h exp 0/8c220004", ramREN, iload); else passed++;
    $display("test_ifetch done");
  endtask

  task automatic test_priority();
    iREN = 1; iaddr = 32'h44; dWEN = 1; dREN = 1; daddr = 32'h100; dstore = 32'hDEAD_BEEF;
    cyc();
    total++; if (ramWEN !== 1'b1 || ramREN !== 1'b0) $display("FAIL pri_en got wen=%b ren=%b exp 1/0", ramWEN, ramREN); else passed++;
    total++; if (ramaddr !== 32'h100 || ramstore !== 32'hDEAD_BEEF) $display("FAIL pri_bus got addr=%h st=%h exp 100/deadbeef", ramaddr, ramstore); else passed++;
    total++; if (iwait !== 1'b1 || dwait !== 1'b1) $display("FAIL pri_wait got %b%b exp 11", iwait, dwait); else passed++;
    cyc();
    ram_ready = 1; ramload = 32'h7777_7777;
    #1;
    total++; if (dwait !== 1'b0 || iwait !== 1'b1) $display("FAIL pri_ddone got dwait=%b iwait=%b exp 0/1", dwait, iwait); else passed++;
    total++; if (dload !== 32'h0) $display("FAIL pri_wr_dload got %h exp 0", dload); else passed++;
    cyc();
    dWEN = 0; dREN = 0; ram_ready = 0;
    #1;
    total++; if (ramREN !== 1'b0 || iwait !== 1'b1) $display("FAIL pri_idle got ren=%b iwait=%b exp 0/1", ramREN, iwait); else passed++;
    cyc();
    total++; if (ramREN !== 1'b1 || ramaddr !== 32'h44) $display("FAIL pri_igrant got ren=%b addr=%h exp 1/44", ramREN, ramaddr); else passed++;
    ram_ready = 1; ramload = 32'h0000_1234;
    #1;
    total++; if (iwait !== 1'b0 || iload !== 32'h1234) $display("FAIL pri_idone got iwait=%b iload=%h exp 0/1234", iwait, iload); else passed++;
    cyc();
    iREN = 0; ram_ready = 0;
    cyc();
    $display("test_priority done");
  endtask

  task automatic test_starvation();
    int dcnt = 0;
    bit seen_i = 0;
    iREN = 1; iaddr = 32'h80; dREN = 1; daddr = 32'h200;
    ramload = 32'h5500_AA55; ram_ready = 1;
    for (int k = 0; k < 40 && !seen_i; k++) begin
      cyc();
      if (ramREN && ramaddr == 32'h200) dcnt++;
      else if (ramREN && ramaddr == 32'h80) seen_i = 1;
    end
    total++; if (dcnt != 4 || !seen_i) $display("FAIL starve_grants got d=%0d seen_i=%0d exp 4/1", dcnt, seen_i); else passed++;
    total++; if (iwait !== 1'b0 || iload !== 32'h5500_AA55) $display("FAIL starve_idone got iwait=%b iload=%h exp 0/5500aa55", iwait, iload); else passed++;
    total++; if (dload !== 32'h5500_AA55) $display("FAIL starve_dload got %h exp 5500aa55", dload); else passed++;
    cyc();
    total++; if (ramREN !== 1'b0) $display("FAIL starve_idle got ren=%b exp 0", ramREN); else passed++;
    cyc();
    total++; if (ramREN !== 1'b1 || ramaddr !== 32'h200 || iwait !== 1'b1) $display("FAIL starve_reset got ren=%b addr=%h iwait=%b exp 1/200/1", ramREN, ramaddr, iwait); else passed++;
    cyc();
    iREN = 0; dREN = 0; ram_ready = 0;
    cyc();
    $display("test_starvation done");
  endtask

  task automatic test_withdraw();
    dREN = 1; daddr = 32'h300; ram_ready = 0;
    cyc();
    iREN = 1; iaddr = 32'h84;
    #1;
    total++; if (ramREN !== 1'b1 || iwait !== 1'b1) $display("FAIL wd_c1 got ren=%b iwait=%b exp 1/1", ramREN, iwait); else passed++;
    cyc();
    dREN = 0; ram_ready = 1; ramload = 32'hFFFF_0000;
    #1;
    total++; if (ramREN !== 1'b0 || dwait !== 1'b0) $display("FAIL wd_drop got ren=%b dwait=%b exp 0/0", ramREN, dwait); else passed++;
    total++; if (dload !== 32'h5500_AA55 || iwait !== 1'b1) $display("FAIL wd_nocomp got dload=%h iwait=%b exp 5500aa55/1", dload, iwait); else passed++;
    cyc();
    ram_ready = 0;
    #1;
    total++; if (ramREN !== 1'b0 || iwait !== 1'b1) $display("FAIL wd_idle got ren=%b iwait=%b exp 0/1", ramREN, iwait); else passed++;
    cyc();
    total++; if (ramREN !== 1'b1 || ramaddr !== 32'h84) $display("FAIL wd_igrant got ren=%b addr=%h exp 1/84", ramREN, ramaddr); else passed++;
    ram_ready = 1; ramload = 32'h8484_0000;
    #1;
    total++; if (iwait !== 1'b0 || iload !== 32'h8484_0000) $display("FAIL wd_idone got iwait=%b iload=%h exp 0/84840000", iwait, iload); else passed++;
    cyc();
    iREN = 0; ram_ready = 0;
    cyc();
    $display("test_withdraw done");
  endtask

  task automatic test_timeout();
    int n = 0;
    iREN = 1; iaddr = 32'h90; ram_ready = 0;
    cyc();
    while (iwait === 1'b1 && n < 30) begin
      n++;
      cyc();
    end
    total++; if (n != 8) $display("FAIL tmo_cycles got %0d exp 8", n); else passed++;
    total++; if (iwait !== 1'b0 || iload !== 32'hBAD1_BAD1) $display("FAIL tmo_abort got iwait=%b iload=%h exp 0/bad1bad1", iwait, iload); else passed++;
    cyc();
    iREN = 0;
    #1;
    total++; if (bus_err !== 1'b1 || ramREN !== 1'b0) $display("FAIL tmo_err got err=%b ren=%b exp 1/0", bus_err, ramREN); else passed++;
    dWEN = 1; daddr = 32'h10; dstore = 32'h1; ram_ready = 1;
    cyc();
    total++; if (dwait !== 1'b0 || ramWEN !== 1'b1) $display("FAIL tmo_after got dwait=%b wen=%b exp 0/1", dwait, ramWEN); else passed++;
    cyc();
    dWEN = 0; ram_ready = 0;
    cyc();
    total++; if (bus_err !== 1'b1) $display("FAIL tmo_sticky got %b exp 1", bus_err); else passed++;
    $display("test_timeout done");
  endtask

  task automatic test_reset_mid();
    dWEN = 1; daddr = 32'h400; dstore = 32'hCAFE_F00D; ram_ready = 0;
    cyc();
    total++; if (ramWEN !== 1'b1) $display("FAIL rm_pre got wen=%b exp 1", ramWEN); else passed++;
    nRST = 1'b0;
    #1;
    total++; if (ramWEN !== 1'b0 || ramstore !== 32'h0) $display("FAIL rm_en got wen=%b st=%h exp 0/0", ramWEN, ramstore); else passed++;
    total++; if (bus_err !== 1'b0 || dwait !== 1'b1) $display("FAIL rm_state got err=%b dwait=%b exp 0/1", bus_err, dwait); else passed++;
    cyc();
    nRST = 1'b1;
    #1;
    total++; if (ramWEN !== 1'b0) $display("FAIL rm_idle got wen=%b exp 0", ramWEN); else passed++;
    cyc();
    total++; if (ramWEN !== 1'b1 || ramaddr !== 32'h400) $display("FAIL rm_resume got wen=%b addr=%h exp 1/400", ramWEN, ramaddr); else passed++;
    ram_ready = 1;
    #1;
    total++; if (dwait !== 1'b0) $display("FAIL rm_done got dwait=%b exp 0", dwait); else passed++;
    cyc();
    dWEN = 0; ram_ready = 0;
    cyc();
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_ifetch();
    test_priority();
    test_starvation();
    test_withdraw();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Single-port memory arbiter between the datapath's instruction-fetch and data-access request paths.
- Serializes requests onto one shared RAM port.
- Holds each grant until the RAM completes the access.
- Data requests have priority; a starvation guard guarantees forward progress for fetches.
- Sits between the datapath/cache request interface and the RAM model; a watchdog timeout reports a hung RAM.

Parameters:
STARVE_LIMIT, 4, max consecutive data grants while an instruction request is pending before instruction is forced.
TIMEOUT, 255, max cycles one access may wait for ram_ready before abort (8-bit counter).

Ports:
CLK  input  1  clock, rising edge
nRST  input  1  asynchronous active-low reset
iREN  input  1  instruction read request
iaddr  input  32  instruction word address
iload  output  32  instruction read data
iwait  output  1  instruction not complete (1 = stall)
dREN  input  1  data read request
dWEN  input  1  data write request
daddr  input  32  data address
dstore  input  32  data write value
dload  output  32  data read data
dwait  output  1  data not complete
ramREN  output  1  RAM read enable
ramWEN  output  1  RAM write enable
ramaddr  output  32  RAM address
ramstore  output  32  RAM write data
ramload  input  32  RAM read data
ram_ready  input  1  RAM access complete this cycle
bus_err  output  1  sticky timeout flag

Behaviour:
- Reset is nRST, asynchronous, active-low; clock is CLK.
- Reset values: state=IDLE, starve_cnt=0, tmo_cnt=0, bus_err=0.
- Reset values of outputs: ram* outputs 0, iload=dload=0, iwait=iREN, dwait=dREN|dWEN. Wait outputs are combinational: asserted whenever the corresponding request is active and not completing this cycle.
- States: IDLE, SERVE_I, SERVE_D.
- IDLE transitions:
  - Go to SERVE_D if (dREN|dWEN) and not (iREN && starve_cnt==STARVE_LIMIT).
  - Else go to SERVE_I if iREN.
  - Else stay in IDLE.
  - No RAM signals are driven in IDLE; the first RAM cycle is the cycle after the grant.
- SERVE_I:
  - Drives ramREN=1, ramaddr=iaddr.
  - On ram_ready: iload=ramload, iwait=0 in the same cycle; go to IDLE.
- SERVE_D:
  - Drives ramWEN=dWEN, ramREN=dREN&~dWEN (dWEN wins if both are set), ramaddr=daddr, ramstore=dstore.
  - On ram_ready: dload=ramload (reads only), dwait=0 in the same cycle; go to IDLE.
- Grant lock: a grant is never preempted. A request arriving during service waits until the state returns to IDLE.
- Minimum latency per access: 1 arbitration cycle + RAM latency.
- Request withdrawal: if the granted requester deasserts all its enables mid-access, go to IDLE next cycle. RAM enables drop combinationally that cycle. No completion is reported.
- starve_cnt:
  - Increments on each transition to SERVE_D while iREN=1, saturating at STARVE_LIMIT.
  - Clears on any transition to SERVE_I, and in any IDLE cycle with iREN=0.
- Timeout:
  - tmo_cnt clears on entry to SERVE_I/SERVE_D and increments each service cycle without ram_ready.
  - When tmo_cnt==TIMEOUT with no ram_ready: abort and go to IDLE, and set bus_err=1 (sticky until reset).
  - For that one cycle the victim's wait=0 and its load=32'hBAD1_BAD1.
- ram_ready in IDLE: ignored.
- Outputs iload/dload hold their last completed value when not completing; they are not registered data paths.
- Reset mid-access: immediate return to IDLE, RAM enables 0, counters 0; no completion is reported.

Test Plan:
1. Reset, then iREN=1, iaddr=0x40, RAM ready after 2 cycles with ramload=0x8C220004 -> ramREN=1, ramaddr=0x40 from cycle 1; iwait=0, iload=0x8C220004 in cycle 3; state returns to IDLE.
2. iREN and dWEN asserted simultaneously, daddr=0x100, dstore=0xDEADBEEF -> data served first with ramWEN=1, ramstore=0xDEADBEEF; iwait held 1 until data completes, then instruction granted.
3. iREN held and dREN re-asserted every cycle, STARVE_LIMIT=4 -> exactly 4 data grants, then a forced instruction grant; starve_cnt back to 0.
4. Data read in progress, dREN dropped in cycle 2 -> ramREN=0 that cycle, IDLE next cycle, dwait never reports completion, a pending iREN is granted next.
5. ram_ready never asserted, TIMEOUT=8 -> abort after 8 service cycles, iwait=0 for 1 cycle with iload=0xBAD1BAD1, bus_err=1 stays set until nRST.
6. nRST pulsed during SERVE_D -> ramWEN=0 immediately, state IDLE, bus_err=0, then normal service resumes.
